// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: shifts the held operand one position per clock in one of four modes.
// Optional sticky (OR of shifted-out bits) output is compiled in with SHIFT_UNIT_STICKY_EN.
module shift_unit_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_UNIT_STICKY_EN
  ,
  output logic             sticky
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
`ifdef SHIFT_UNIT_STICKY_EN
  logic             r_sticky;
  logic             w_sticky_nxt;
`endif

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] res;
    case (m)
      2'b00:   res = {1'b0, d[WIDTH-1:1]};
      2'b01:   res = {d[WIDTH-1], d[WIDTH-1:1]};
      2'b10:   res = {d[WIDTH-2:0], 1'b0};
      2'b11:   res = {d[0], d[WIDTH-1:1]};
      default: res = d;
    endcase
    return res;
  endfunction

`ifdef SHIFT_UNIT_STICKY_EN
  // Bit that leaves the operand on one step; rotate loses nothing.
  function automatic logic f_out_bit(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic b;
    case (m)
      2'b00, 2'b01: b = d[0];
      2'b10:        b = d[WIDTH-1];
      default:      b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef SHIFT_UNIT_STICKY_EN
    w_sticky_nxt = r_sticky;
`endif
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_data_nxt = data_in;
        end else begin
          w_data_nxt = r_data;
        end
        if (start) begin
          w_mode_nxt = mode;
          w_cnt_nxt  = amount;
`ifdef SHIFT_UNIT_STICKY_EN
          w_sticky_nxt = 1'b0;
`endif
          if (amount != {AMT_W{1'b0}}) begin
            w_state_nxt = ST_SHIFT;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_data_nxt = f_shift(r_data, r_mode);
        w_cnt_nxt  = r_cnt - AMT_W'(1'b1);
`ifdef SHIFT_UNIT_STICKY_EN
        w_sticky_nxt = r_sticky | f_out_bit(r_data, r_mode);
`endif
        // The edge that performs the last step also finishes the operation.
        if (r_cnt == AMT_W'(1'b1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= {WIDTH{1'b0}};
      r_cnt   <= {AMT_W{1'b0}};
      r_mode  <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SHIFT_UNIT_STICKY_EN
      r_sticky <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef SHIFT_UNIT_STICKY_EN
      r_sticky <= w_sticky_nxt;
`endif
    end
  end

  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
`ifdef SHIFT_UNIT_STICKY_EN
  assign sticky   = r_sticky;
`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Randomized self-checking bench for shift_unit_seq against an arithmetic reference model.
module tb_shift_unit_seq;
  localparam int W     = 4;
  localparam int AMT_W = 3;

  logic             clock;
  logic             reset;
  logic             load;
  logic [W-1:0]     data_in;
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [W-1:0]     data_out;
  logic             busy;
  logic             done;
`ifdef SHIFT_UNIT_STICKY_EN
  logic             sticky;
`endif

  int n_total;
  int n_bad;
  logic [W-1:0] m_data;

  shift_unit_seq #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .start   (start),
    .mode    (mode),
    .amount  (amount),
    .data_out(data_out),
    .busy    (busy),
    .done    (done)
`ifdef SHIFT_UNIT_STICKY_EN
    ,
    .sticky  (sticky)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result of shifting d by k positions, from the mode's arithmetic meaning.
  function automatic logic [W-1:0] exp_shift(input logic [W-1:0] d, input logic [1:0] md, input int k);
    logic signed [W-1:0] s;
    logic [2*W-1:0]      dd;
    s  = d;
    dd = {d, d};
    case (md)
      2'b00:   return d >> k;
      2'b01:   return W'(s >>> k);
      2'b10:   return d << k;
      default: return W'(dd >> (k % W));
    endcase
  endfunction

  // Whether any 1 bit leaves the operand during k steps.
  function automatic logic exp_sticky(input logic [W-1:0] d, input logic [1:0] md, input int k);
    logic [W-1:0] ones;
    logic [W-1:0] mask;
    ones = {W{1'b1}};
    case (md)
      2'b00, 2'b01: mask = (k >= W) ? ones : ~(ones << k);
      2'b10:        mask = (k >= W) ? ones : ~(ones >> k);
      default:      mask = {W{1'b0}};
    endcase
    return |(d & mask);
  endfunction

  // Starts one operation at a negedge and checks it through completion; junk is driven while busy.
  task automatic run_op(input string tag, input bit ld, input logic [W-1:0] din,
                        input logic [1:0] md, input int amt, input bit chain);
    logic [W-1:0] op;
    int steps;
    load    = ld;
    data_in = din;
    start   = 1'b1;
    mode    = md;
    amount  = AMT_W'(amt);
    if (ld) m_data = din;
    op = m_data;
    @(negedge clock);
    load  = 1'b0;
    start = 1'b0;
    steps = 0;
    while (busy && steps < 40) begin
      check_eq({tag, "_step"}, 32'(data_out), 32'(exp_shift(op, md, steps)));
      load    = 1'($urandom);
      start   = 1'($urandom);
      data_in = W'($urandom);
      mode    = 2'($urandom);
      amount  = AMT_W'($urandom);
      @(negedge clock);
      steps++;
    end
    load  = 1'b0;
    start = 1'b0;
    m_data = exp_shift(op, md, amt);
    check_eq({tag, "_busy_cycles"}, 32'(steps), 32'(amt));
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_data"}, 32'(data_out), 32'(m_data));
`ifdef SHIFT_UNIT_STICKY_EN
    check_eq({tag, "_sticky"}, 32'(sticky), 32'(exp_sticky(op, md, amt)));
`endif
    if (!chain) begin
      @(negedge clock);
      check_eq({tag, "_done_clear"}, 32'(done), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_hold"}, 32'(data_out), 32'(m_data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_data  = {W{1'b0}};
    reset   = 1'b1;
    load    = 1'b0;
    start   = 1'b0;
    data_in = {W{1'b0}};
    mode    = 2'b00;
    amount  = {AMT_W{1'b0}};
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
`ifdef SHIFT_UNIT_STICKY_EN
    check_eq("rst_sticky", 32'(sticky), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    run_op("asr2", 1'b1, 4'b1011, 2'b01, 2, 1'b0);
    run_op("lsr5", 1'b1, 4'b1011, 2'b00, 5, 1'b0);
    run_op("rot1", 1'b1, 4'b0001, 2'b11, 1, 1'b1);
    run_op("rot4", 1'b0, 4'b0000, 2'b11, 4, 1'b0);
    run_op("lsl1", 1'b1, 4'b1001, 2'b10, 1, 1'b1);
    run_op("amt0", 1'b0, 4'b0000, 2'b10, 0, 1'b0);
    run_op("proto", 1'b1, 4'b1111, 2'b00, 3, 1'b0);
    check_eq("plan_proto", 32'(data_out), 32'(4'b0001));

    // Reset between the first and second step of a 4-step shift.
    load    = 1'b1;
    data_in = 4'b1010;
    start   = 1'b1;
    mode    = 2'b00;
    amount  = AMT_W'(4);
    @(negedge clock);
    load  = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check_eq("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_data", 32'(data_out), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_done", 32'(done), 32'd0);
`ifdef SHIFT_UNIT_STICKY_EN
    check_eq("async_rst_sticky", 32'(sticky), 32'd0);
`endif
    @(negedge clock);
    reset  = 1'b0;
    m_data = {W{1'b0}};
    @(negedge clock);
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    run_op("post_rst", 1'b1, 4'b0110, 2'b01, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rnd", 1'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 7)),
             1'($urandom));
    end
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised multi-cycle shifter: shifts a held operand one bit position per clock until a requested amount is reached.
- Four modes: logical right, arithmetic right, logical left, rotate right.
- Start/busy/done handshake, so it can sit behind a datapath controller as the shift stage of a small ALU.
- Generalises the fixed 4-bit, shift-by-2 arithmetic shifter to any width, any amount and multiple modes.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).
- AMT_W, 3, width of the shift-amount input; amounts 0 to 2^AMT_W-1 are legal, including amounts >= WIDTH.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture data_in into the operand register.
- data_in  input  WIDTH  operand to load.
- start  input  1  begin a shift operation.
- mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- amount  input  AMT_W  number of single-bit shift steps.
- data_out  output  WIDTH  operand/result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.
- sticky  output  1  only present when the optional feature is compiled in.

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - data_out=0, busy=0, done=0, sticky=0.
  - Step counter=0, state=IDLE.
  - Any shift in progress is abandoned.
- States: IDLE, SHIFT.
- IDLE:
  - load=1 loads data_in into data_out at the edge.
  - start=1 latches mode and amount.
  - If load and start are both high in the same cycle, the newly loaded value is the operand.
  - amount!=0: go to SHIFT, counter=amount, busy=1 from that edge.
  - amount==0: stay IDLE, data_out unchanged (apart from any load), done=1 for the following cycle.
- SHIFT, one step per edge using the latched mode:
  - 00: {0, d[W-1:1]}
  - 01: {d[W-1], d[W-1:1]}
  - 10: {d[W-2:0], 0}
  - 11: {d[0], d[W-1:1]}
  - Counter decrements each step.
  - The edge performing the final step returns the FSM to IDLE, clears busy and sets done.
- Latency: start sampled at edge T0; shifts occur at T1..Tn (n=amount); done is high for the cycle after Tn; busy is high from T0 to Tn.
- done is high for exactly one cycle and clears at the next edge.
- While busy=1, load and start are ignored, and mode/amount changes have no effect.
- start in the same cycle done is high is accepted normally (back-to-back operation).
- Amounts >= WIDTH continue stepping with no clamping:
  - logical modes reach all-zero;
  - arithmetic reaches all sign bit;
  - rotate wraps modulo WIDTH.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SHIFT_UNIT_STICKY_EN.
- Defined:
  - sticky output port exists.
  - Cleared at any accepted start.
  - Each SHIFT step ORs in the bit shifted out: d[0] for modes 00/01, d[W-1] for mode 10.
  - Stays 0 in mode 11.
  - Holds its value in IDLE until the next start or reset.
- Not defined: no sticky port, no sticky register; all other behaviour identical.

Test Plan (WIDTH=4, AMT_W=3):
1. Arithmetic right: load 4'b1011 with start, mode 01, amount 2 -> data_out 1101 after T1, 1110 after T2; busy high for 2 cycles; done pulses once; sticky=1.
2. Logical right, oversized: load 1011, start mode 00 amount 5 -> data_out 0000 after T5; busy exactly 5 cycles; done 1 cycle.
3. Rotate: load 0001, mode 11 amount 1 -> 1000. Then start again in the done cycle with amount 4 -> 1000 after 4 steps (full wrap); sticky=0.
4. Logical left: load 1001, mode 10 amount 1 -> 0010, sticky=1. Then amount 0 -> done next cycle, data_out stays 0010, busy never rises.
5. Protocol: start mode 00 amount 3 on 1111; pulse load=1 data_in=0000 and start at T1 -> both ignored; result 0001 after T3.
6. Reset mid-operation: assert reset between T1 and T2 of a 4-step shift -> data_out=0, busy=0, done=0 immediately; after release, a new load/start runs normally.
